// File: rtl/board_input_conditioner_if.sv
// Pin-side and system-side signals of the board input conditioner.
// Latency: none (wiring only).
// Backpressure: none; every signal is a level or a single-cycle pulse.
interface board_input_conditioner_if #(
    parameter int N_KEYS = 2,
    parameter int N_SW   = 10
) ();
    // Raw board pins (asynchronous to the system clock)
    logic [N_KEYS-1:0] key_n_in;
    logic [N_SW-1:0]   sw_in;

    // Conditioned outputs in the system clock domain
    logic [N_KEYS-1:0] pushbuttons_out;
    logic [N_SW-1:0]   switches_out;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic              sw_change;

    // Board / stimulus side: drives pins, observes conditioned values
    modport master (
        output key_n_in,
        output sw_in,
        input  pushbuttons_out,
        input  switches_out,
        input  key_press,
        input  key_release,
        input  sw_change
    );

    // Conditioner side
    modport slave (
        input  key_n_in,
        input  sw_in,
        output pushbuttons_out,
        output switches_out,
        output key_press,
        output key_release,
        output sw_change
    );
endinterface

// File: rtl/board_input_conditioner.sv
// Synchronizes, debounces and edge-detects DE10-Lite KEY/SW pins for the Qsys system.
// Latency: 2 + DB_CYCLES clk_clk edges from pin step to level output, +1 for pulses.
// Backpressure: none; outputs are levels and single-cycle pulses. Macro KEY_REPEAT_EN adds key auto-repeat.
module board_input_conditioner #(
    parameter int N_KEYS               = 2,
    parameter int N_SW                 = 10,
    parameter int DB_CYCLES            = 500000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    board_input_conditioner_if.slave io
);

    localparam int N_BITS = N_KEYS + N_SW;
    localparam int CW     = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    // Keys occupy the low bits, switches the high bits; everything active-high.
    logic [N_BITS-1:0] raw;
    logic [N_BITS-1:0] sync0;
    logic [N_BITS-1:0] sync1;
    logic [N_BITS-1:0] db;
    logic [N_BITS-1:0] db_d;

    logic [N_KEYS-1:0] key_db;
    logic [N_KEYS-1:0] key_db_d;
    logic [N_SW-1:0]   sw_db;
    logic [N_SW-1:0]   sw_db_d;
    logic [N_KEYS-1:0] rep_fire;

    logic [N_KEYS-1:0] key_press_q;
    logic [N_KEYS-1:0] key_release_q;
    logic              sw_change_q;

    // Keys are inverted before the synchronizer so reset value 0 means "not pressed".
    assign raw = {io.sw_in, ~io.key_n_in};

    // Two-flop synchronizer for every pin
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync0 <= '0;
            sync1 <= '0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
        end
    end

    generate
        for (genvar b = 0; b < N_BITS; b++) begin : g_db
            logic [CW-1:0] cnt;
            logic          db_bit;

            // Output only moves after sync1 has disagreed for DB_CYCLES consecutive cycles
            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n) begin
                    cnt    <= '0;
                    db_bit <= 1'b0;
                end else if (sync1[b] == db_bit) begin
                    cnt <= '0;
                end else if (cnt == DB_LAST) begin
                    db_bit <= sync1[b];
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign db[b] = db_bit;
        end
    endgenerate

    assign key_db   = db[N_KEYS-1:0];
    assign key_db_d = db_d[N_KEYS-1:0];
    assign sw_db    = db[N_BITS-1:N_KEYS];
    assign sw_db_d  = db_d[N_BITS-1:N_KEYS];

`ifdef KEY_REPEAT_EN
    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RW      = (RPT_MAX < 1) ? 1 : $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD_CYCLES - 1);

    generate
        for (genvar k = 0; k < N_KEYS; k++) begin : g_rpt
            rpt_state_t    state;
            rpt_state_t    state_nxt;
            logic [RW-1:0] rcnt;
            logic [RW-1:0] rcnt_nxt;
            logic          fire;

            // Repeat state and hold-time counter
            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n) begin
                    state <= RPT_IDLE;
                    rcnt  <= '0;
                end else begin
                    state <= state_nxt;
                    rcnt  <= rcnt_nxt;
                end
            end

            // Fire only while the debounced key is still held, so a repeat
            // can never land in the same cycle as the release pulse.
            always_comb begin
                state_nxt = state;
                rcnt_nxt  = rcnt;
                fire      = 1'b0;
                case (state)
                    RPT_IDLE: begin
                        if (key_db[k]) begin
                            state_nxt = RPT_DELAY;
                            rcnt_nxt  = '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (!key_db[k]) begin
                            state_nxt = RPT_IDLE;
                            rcnt_nxt  = '0;
                        end else if (rcnt == DELAY_LAST) begin
                            state_nxt = RPT_REPEAT;
                            rcnt_nxt  = '0;
                            fire      = 1'b1;
                        end else begin
                            rcnt_nxt = rcnt + 1'b1;
                        end
                    end
                    RPT_REPEAT: begin
                        if (!key_db[k]) begin
                            state_nxt = RPT_IDLE;
                            rcnt_nxt  = '0;
                        end else if (rcnt == PERIOD_LAST) begin
                            rcnt_nxt = '0;
                            fire     = 1'b1;
                        end else begin
                            rcnt_nxt = rcnt + 1'b1;
                        end
                    end
                    default: begin
                        state_nxt = RPT_IDLE;
                        rcnt_nxt  = '0;
                    end
                endcase
            end

            assign rep_fire[k] = fire;
        end
    endgenerate
`else
    // Without auto-repeat the repeat timing parameters have no effect.
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES};
    assign rep_fire       = '0;
`endif

    // Registered edge detection on the debounced levels
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            db_d          <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
            sw_change_q   <= 1'b0;
        end else begin
            db_d          <= db;
            key_press_q   <= (key_db & ~key_db_d) | rep_fire;
            key_release_q <= ~key_db & key_db_d;
            sw_change_q   <= |(sw_db ^ sw_db_d);
        end
    end

    assign io.pushbuttons_out = key_db;
    assign io.switches_out    = sw_db;
    assign io.key_press       = key_press_q;
    assign io.key_release     = key_release_q;
    assign io.sw_change       = sw_change_q;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed bench for board_input_conditioner with a short debounce window.
// Latency: pin step seen at step j gives level at j+5 and pulse at j+6.
// Backpressure: none.
module tb_board_input_conditioner;

    localparam int N_KEYS = 2;
    localparam int N_SW   = 10;
    localparam int DB     = 4;
    localparam int RDELAY = 10;
    localparam int RPER   = 4;
    localparam int NV     = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    board_input_conditioner_if #(.N_KEYS(N_KEYS), .N_SW(N_SW)) bif ();

    board_input_conditioner #(
        .N_KEYS(N_KEYS),
        .N_SW(N_SW),
        .DB_CYCLES(DB),
        .REPEAT_DELAY_CYCLES(RDELAY),
        .REPEAT_PERIOD_CYCLES(RPER)
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .io(bif.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] key_n;
        logic [9:0] sw;
        logic [1:0] pb;
        logic [9:0] swo;
        logic [1:0] press;
        logic [1:0] rel;
        logic       chg;
    } vec_t;

    vec_t vecs[NV];

    task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int step, input logic [1:0] pb, input logic [9:0] swo,
                             input logic [1:0] press, input logic [1:0] rel, input logic chg);
        check({tag, ".pushbuttons_out"}, step, 32'(bif.pushbuttons_out), 32'(pb));
        check({tag, ".switches_out"},    step, 32'(bif.switches_out),    32'(swo));
        check({tag, ".key_press"},       step, 32'(bif.key_press),       32'(press));
        check({tag, ".key_release"},     step, 32'(bif.key_release),     32'(rel));
        check({tag, ".sw_change"},       step, 32'(bif.sw_change),       32'(chg));
    endtask

    // One clock edge, then settle away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pb_rise, sw_rise, press_cnt, press_step, chg_cnt, chg_step;
        logic [1:0] exp_press;

        bif.key_n_in = 2'b11;
        bif.sw_in    = '0;
        rst_n        = 1'b0;

        // Reset held 3 cycles with idle pins
        repeat (3) tick();
        check_all("in_reset", 0, 2'b00, 10'h000, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_all("after_reset", i, 2'b00, 10'h000, 2'b00, 2'b00, 1'b0);
        end

        // Vector table: clean press/release of key 0, then bounce on sw[3]
        for (int i = 0; i < NV; i++) begin
            vecs[i] = '{key_n: 2'b11, sw: 10'h000, pb: 2'b00, swo: 10'h000,
                        press: 2'b00, rel: 2'b00, chg: 1'b0};
        end
        for (int i = 1; i <= 9; i++)  vecs[i].key_n = 2'b10;
        for (int i = 6; i <= 14; i++) vecs[i].pb = 2'b01;
        vecs[7].press = 2'b01;
        vecs[16].rel  = 2'b01;
        vecs[20].sw = 10'h008;
        vecs[21].sw = 10'h008;
        vecs[24].sw = 10'h008;
        vecs[25].sw = 10'h008;
        for (int i = 28; i < NV; i++) vecs[i].sw  = 10'h008;
        for (int i = 33; i < NV; i++) vecs[i].swo = 10'h008;
        vecs[34].chg = 1'b1;

        for (int i = 0; i < NV; i++) begin
            bif.key_n_in = vecs[i].key_n;
            bif.sw_in    = vecs[i].sw;
            tick();
            check_all("table", i, vecs[i].pb, vecs[i].swo, vecs[i].press, vecs[i].rel, vecs[i].chg);
        end

        // Back to idle
        bif.sw_in = '0;
        repeat (12) tick();
        check("idle.switches_out", 0, 32'(bif.switches_out), 32'h0);

        // Simultaneous: all switches on and both keys pressed on the same edge
        bif.key_n_in = 2'b00;
        bif.sw_in    = 10'h3FF;
        pb_rise = -1; sw_rise = -1; press_cnt = 0; press_step = -1; chg_cnt = 0; chg_step = -1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (pb_rise < 0 && bif.pushbuttons_out == 2'b11) pb_rise = k;
            if (sw_rise < 0 && bif.switches_out == 10'h3FF) sw_rise = k;
            if (bif.key_press != 2'b00) begin
                press_cnt++;
                if (bif.key_press == 2'b11) press_step = k;
            end
            if (bif.sw_change) begin
                chg_cnt++;
                chg_step = k;
            end
        end
        check("simul.pb_rise_step",  0, 32'(pb_rise),    32'd5);
        check("simul.sw_rise_step",  0, 32'(sw_rise),    32'd5);
        check("simul.press_cycles",  0, 32'(press_cnt),  32'd1);
        check("simul.press_step",    0, 32'(press_step), 32'd6);
        check("simul.chg_pulses",    0, 32'(chg_cnt),    32'd1);
        check("simul.chg_step",      0, 32'(chg_step),   32'd6);

        bif.key_n_in = 2'b11;
        bif.sw_in    = '0;
        repeat (12) tick();
        check("simul_idle.pushbuttons_out", 0, 32'(bif.pushbuttons_out), 32'h0);

        // Reset mid-debounce: count is one short of qualifying when reset hits
        bif.key_n_in = 2'b10;
        repeat (5) tick();
        check("mid.pushbuttons_out_pre", 0, 32'(bif.pushbuttons_out), 32'h0);
        rst_n = 1'b0;
        tick();
        check_all("mid_in_reset", 0, 2'b00, 10'h000, 2'b00, 2'b00, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("mid.pushbuttons_out", k, 32'(bif.pushbuttons_out), (k >= 5) ? 32'h1 : 32'h0);
            check("mid.key_press",       k, 32'(bif.key_press),       (k == 6) ? 32'h1 : 32'h0);
        end
        bif.key_n_in = 2'b11;
        repeat (10) tick();

        // Long hold of key 1: auto-repeat when enabled, otherwise a single press
        bif.key_n_in = 2'b01;
        for (int k = 0; k < 57; k++) begin
            if (k == 45) bif.key_n_in = 2'b11;
            tick();
`ifdef KEY_REPEAT_EN
            exp_press = ((k == 6) || (k >= 16 && k <= 48 && ((k - 16) % 4) == 0)) ? 2'b10 : 2'b00;
`else
            exp_press = (k == 6) ? 2'b10 : 2'b00;
`endif
            check("hold.key_press",   k, 32'(bif.key_press),   32'(exp_press));
            check("hold.key_release", k, 32'(bif.key_release), (k == 51) ? 32'h2 : 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/board_input_conditioner.md
Name: board_input_conditioner

Overview:
- Conditions the raw DE10-Lite KEY[1:0] and SW[9:0] pins before they reach the Computer_System pushbuttons_export and slider_switches_export inputs.
- Pipeline per bit: 2-FF synchronizer, counter-based debounce, press/release edge pulses.
- Sits in the board top level, directly upstream of the Qsys system; all outputs are in the system clock domain.

Parameters:
- N_KEYS, 2, number of pushbuttons; pins are active-low.
- N_SW, 10, number of slide switches; pins are active-high.
- DB_CYCLES, 500000, cycles a synchronized input must differ continuously from the debounced value before that value updates (10 ms at 50 MHz); legal range >= 1.
- REPEAT_DELAY_CYCLES, 25000000, hold time before the first auto-repeat pulse (KEY_REPEAT_EN only).
- REPEAT_PERIOD_CYCLES, 5000000, interval between subsequent auto-repeat pulses (KEY_REPEAT_EN only).

Ports:
- clk_clk  input  1  system clock, shared with the Qsys system.
- reset_reset_n  input  1  asynchronous active-low reset.
- key_n_in  input  N_KEYS  raw KEY pins, active-low, asynchronous.
- sw_in  input  N_SW  raw SW pins, asynchronous.
- pushbuttons_out  output  N_KEYS  debounced keys, active-high (1 = pressed); drives pushbuttons_export.
- switches_out  output  N_SW  debounced switches; drives slider_switches_export.
- key_press  output  N_KEYS  1-cycle pulse on each debounced press, plus auto-repeat pulses when enabled.
- key_release  output  N_KEYS  1-cycle pulse on each debounced release.
- sw_change  output  1  1-cycle pulse when any switches_out bit changes.

Behaviour:
- Reset is asynchronous assert, released on a clk_clk edge.
- Reset values: all outputs 0, synchronizer flops 0 (key sync flops hold the inverted, i.e. active-high, value), all counters 0.
- Keys are inverted before synchronizing, so every downstream stage is active-high.
- Synchronizer: 2 flops per bit. A pin change is visible at sync[1] after 2 edges.
- Debounce, per bit, counter width clog2(DB_CYCLES+1):
  - sync == debounced: counter cleared to 0.
  - sync != debounced and counter < DB_CYCLES-1: counter increments.
  - sync != debounced and counter == DB_CYCLES-1: debounced <= sync, counter cleared.
- Any glitch shorter than DB_CYCLES cycles restarts the count and never reaches the output.
- Latency: a clean pin step appears on the output 2+DB_CYCLES edges after the pin change.
- key_press[i] / key_release[i]: registered edge detect of pushbuttons_out[i]. Each is high for exactly the cycle after the output rises / falls.
- sw_change: registered OR of per-bit changes of switches_out; high for 1 cycle. Simultaneous multi-bit changes give a single pulse.
- Keys are independent: a simultaneous press of both keys pulses both bits in the same cycle.
- Reset mid-debounce discards the pending count. After release, a held key or on-switch re-qualifies after 2+DB_CYCLES cycles and produces the normal press / sw_change pulse.
- DB_CYCLES = 1: output follows sync[1] with 1 cycle of added delay (no filtering).

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - Each key gets a repeat counter, width clog2(max(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES)+1).
  - Per-key state machine IDLE -> DELAY -> REPEAT:
    - IDLE -> DELAY on debounced press (normal key_press pulse issued).
    - DELAY -> REPEAT after REPEAT_DELAY_CYCLES cycles held; issues a key_press pulse.
    - In REPEAT, a key_press pulse every REPEAT_PERIOD_CYCLES cycles.
    - Debounced release from any state -> IDLE, counter cleared, key_release pulse.
  - Repeat pulses never coincide with the release cycle.
- Undefined: no repeat logic and no repeat flops; exactly one key_press pulse per press. REPEAT_* parameters are ignored.

Test Plan:
- Reset check: DB_CYCLES=4, pins idle (key_n_in=2'b11, sw_in=0), reset_reset_n low 3 cycles then high -> all outputs 0, no pulses for 20 cycles.
- Clean press: key_n_in[0] 1->0 at edge t -> pushbuttons_out=2'b01 at t+6; key_press=2'b01 for exactly 1 cycle at t+7; release 0->1 -> key_release[0] 1-cycle pulse 7 cycles later.
- Bounce rejection: sw_in[3] toggles 1,0,1,0 every 2 cycles, then holds 1 -> switches_out[3] rises exactly 6 cycles after the final edge; exactly one sw_change pulse.
- Simultaneous events: sw_in 0 -> 10'h3FF and key_n_in 11 -> 00 on the same edge -> switches_out=10'h3FF and pushbuttons_out=2'b11 on the same cycle; one sw_change pulse; key_press=2'b11 for one cycle.
- Reset mid-debounce: key held 3 cycles after sync, then reset pulsed -> outputs stay 0; with the key still held, pushbuttons_out=1 six cycles after reset release.
- KEY_REPEAT_EN, DELAY=10, PERIOD=4: hold key[1] 40 cycles -> key_press[1] pulses at output-rise+1, then +10, then every 4 cycles; no pulse after release.
